// File: rtl/cla_pkg.sv
// cla_pkg: group width, stage count helper and per-stage pipeline record
package cla_pkg;
  localparam int GROUP_W = 4;
  typedef struct packed {
    logic                valid;
    logic                carry;
    logic [GROUP_W-1:0]  psum;
  } stage_t;
  function automatic int num_groups(input int width);
    return width / GROUP_W;
  endfunction
endpackage

// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if: operand/result valid-ready bundle for cla_pipe_adder
interface cla_pipe_adder_if #(parameter int WIDTH = 16);
  logic             in_valid, in_ready, cin, sub;
  logic             out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, s;
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, s, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, s, cout, ovf);
endinterface

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit two-level carry-lookahead group
module cla_group4 import cla_pkg::*; (
  input  logic [GROUP_W-1:0] a4,
  input  logic [GROUP_W-1:0] b4,
  input  logic               ci,
  output logic [GROUP_W-1:0] s4,
  output logic               co,
  output logic               c3
);
  logic [GROUP_W-1:0] g, p;
  logic [GROUP_W:0]   c;
  assign g    = a4 & b4;
  assign p    = a4 ^ b4;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s4   = p ^ c[GROUP_W-1:0];
  assign co   = c[GROUP_W];
  assign c3   = c[GROUP_W-1];
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: one lookahead group per pipeline stage, valid/ready stall; CLA_SAT_EN clamps s on signed overflow
module cla_pipe_adder import cla_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int NG = num_groups(WIDTH);
  logic             adv, c_eff, c3_top;
  logic [WIDTH-1:0] b_eff, s_d, s_q;
  logic             v_d, v_q, cout_d, cout_q, ovf_d, ovf_q;
  assign adv   = ~v_q | bus.out_ready;
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub ? ~bus.cin : bus.cin;
  for (genvar k = 0; k < NG; k++) begin : g_st
    localparam int HW = WIDTH - GROUP_W * k;
    localparam int RW = GROUP_W * (k + 1);
    logic [HW-1:0]      op_a, op_b;
    logic [RW-1:0]      res;
    logic [GROUP_W-1:0] s4;
    logic               ci, vi, co;
    if (k == 0) begin : g_src
      assign op_a = bus.a;
      assign op_b = b_eff;
      assign ci   = c_eff;
      assign vi   = bus.in_valid;
      assign res  = s4;
    end else begin : g_src
      assign op_a = g_st[k-1].g_reg.ha_q;
      assign op_b = g_st[k-1].g_reg.hb_q;
      assign ci   = g_st[k-1].g_reg.st_q.carry;
      assign vi   = g_st[k-1].g_reg.st_q.valid;
      assign res  = {s4, g_st[k-1].g_reg.done};
    end
    if (k == NG - 1) begin : g_grp
      cla_group4 u_grp (.a4(op_a[GROUP_W-1:0]), .b4(op_b[GROUP_W-1:0]), .ci(ci),
                        .s4(s4), .co(co), .c3(c3_top));
    end else begin : g_grp
      cla_group4 u_grp (.a4(op_a[GROUP_W-1:0]), .b4(op_b[GROUP_W-1:0]), .ci(ci),
                        .s4(s4), .co(co), .c3());
    end
    if (k < NG - 1) begin : g_reg
      stage_t                 st_d, st_q;
      logic [HW-GROUP_W-1:0]  ha_d, hb_d, ha_q, hb_q;
      logic [RW-1:0]          done;
      always_comb begin
        st_d = '{valid: vi, carry: co, psum: res[RW-1 -: GROUP_W]};
        ha_d = op_a[HW-1:GROUP_W];
        hb_d = op_b[HW-1:GROUP_W];
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          st_q <= '0;
          ha_q <= '0;
          hb_q <= '0;
        end else if (adv) begin
          st_q <= st_d;
          ha_q <= ha_d;
          hb_q <= hb_d;
        end
      if (k == 0) begin : g_lo
        assign done = st_q.psum;
      end else begin : g_lo
        logic [RW-GROUP_W-1:0] lo_d, lo_q;
        assign lo_d = res[RW-GROUP_W-1:0];
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) lo_q <= '0;
          else if (adv) lo_q <= lo_d;
        assign done = {st_q.psum, lo_q};
      end
    end
  end
  // Last stage writes straight into the output register so latency stays NG
  always_comb begin
    v_d    = g_st[NG-1].vi;
    cout_d = g_st[NG-1].co;
    ovf_d  = c3_top ^ g_st[NG-1].co;
`ifdef CLA_SAT_EN
    s_d    = ovf_d ? {g_st[NG-1].op_a[GROUP_W-1], {(WIDTH-1){~g_st[NG-1].op_a[GROUP_W-1]}}}
                   : g_st[NG-1].res;
`else
    s_d    = g_st[NG-1].res;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q    <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      v_q    <= v_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: randomized and directed checks of 16-bit and 4-bit instances against an arithmetic model
module tb_cla_pipe_adder;
  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  cla_pipe_adder_if #(.WIDTH(16)) if16 ();
  cla_pipe_adder_if #(.WIDTH(4))  if4 ();
  cla_pipe_adder #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  cla_pipe_adder #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint m, ua, ub, sa, sb, u, sv;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    u  = sub ? ua - ub - longint'(cin) : ua + ub + longint'(cin);
    sv = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
    r.cout = sub ? (u >= 0) : (u >= m);
    r.ovf  = (sv < -(m / 2)) || (sv >= m / 2);
    r.s    = 16'(u & (m - 1));
`ifdef CLA_SAT_EN
    if (r.ovf) r.s = (sa < 0) ? 16'(m / 2) : 16'(m / 2 - 1);
`endif
    return r;
  endfunction

  task automatic test_reset;
    #12;
    checks++;
    if ({if16.out_valid, if16.s, if16.cout, if16.ovf, if4.out_valid} !== 20'h0)
      begin errors++; $display("FAIL reset_state: got v=%b s=%h c=%b o=%b v4=%b expected all 0",
        if16.out_valid, if16.s, if16.cout, if16.ovf, if4.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0",
        if16.in_ready, if16.out_valid); end
  endtask

  task automatic test_directed;
    logic [15:0] ta[4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] tb[4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        tsub[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef CLA_SAT_EN
    logic [15:0] es[4] = '{16'h0000, 16'h7FFF, 16'hFFFE, 16'h8000};
`else
    logic [15:0] es[4] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
`endif
    logic        ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if16.out_ready = 1'b1;
      if16.in_valid  = 1'b1;
      if16.a = ta[i]; if16.b = tb[i]; if16.cin = 1'b0; if16.sub = tsub[i];
      @(negedge clk);
      if16.in_valid = 1'b0;
      lat = 1;
      while (!if16.out_valid && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL directed[%0d] latency: got %0d expected 4", i, lat); end
      checks++;
      if ({if16.s, if16.cout, if16.ovf} !== {es[i], ec[i], eo[i]})
        begin errors++; $display("FAIL directed[%0d] result: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
          i, if16.s, if16.cout, if16.ovf, es[i], ec[i], eo[i]); end
    end
  endtask

  task automatic test_back_to_back;
    res_t q[$];
    res_t e;
    int sent = 0, got = 0, stall = 0, cyc = 0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if16.out_ready = (stall == 0);
      if16.in_valid  = (sent < 8);
      if16.a = 16'(sent); if16.b = 16'(sent * 16'h1000); if16.cin = 1'b0; if16.sub = 1'b0;
      #1;
      checks++;
      if (if16.in_ready !== (stall == 0))
        begin errors++; $display("FAIL b2b in_ready cyc %0d: got %b expected %b", cyc, if16.in_ready, stall == 0); end
      if (stall > 0) begin
        checks++;
        if (q.size() == 0 || if16.out_valid !== 1'b1 || if16.s !== q[0].s)
          begin errors++; $display("FAIL b2b hold cyc %0d: got v=%b s=%h expected held result", cyc, if16.out_valid, if16.s); end
        stall--;
      end
      if (if16.in_valid && if16.in_ready) begin
        q.push_back(model(16, if16.a, if16.b, 1'b0, 1'b0));
        sent++;
      end
      if (if16.out_valid && if16.out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b spurious: got s=%h expected no result", if16.s); end
        else begin
          e = q.pop_front();
          if ({if16.s, if16.cout, if16.ovf} !== {e.s, e.cout, e.ovf})
            begin errors++; $display("FAIL b2b result %0d: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
              got, if16.s, if16.cout, if16.ovf, e.s, e.cout, e.ovf); end
        end
        got++;
        if (got == 2) stall = 3;
      end
    end
    if16.in_valid = 1'b0;
    checks++;
    if (got != 8) begin errors++; $display("FAIL b2b count: got %0d expected 8", got); end
  endtask

  task automatic test_random16;
    res_t q[$];
    res_t e;
    int sent = 0, got = 0, cyc = 0;
    while (got < 300 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if16.out_ready = ($urandom_range(0, 3) != 0);
      if16.in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
      if16.a = 16'($urandom); if16.b = 16'($urandom);
      if16.cin = 1'($urandom); if16.sub = 1'($urandom);
      #1;
      if (if16.in_valid && if16.in_ready) begin
        q.push_back(model(16, if16.a, if16.b, if16.cin, if16.sub));
        sent++;
      end
      if (if16.out_valid && if16.out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rand16 spurious: got s=%h expected no result", if16.s); end
        else begin
          e = q.pop_front();
          if ({if16.s, if16.cout, if16.ovf} !== {e.s, e.cout, e.ovf})
            begin errors++; $display("FAIL rand16 result %0d: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
              got, if16.s, if16.cout, if16.ovf, e.s, e.cout, e.ovf); end
        end
        got++;
      end
    end
    if16.in_valid = 1'b0;
    checks++;
    if (got != 300) begin errors++; $display("FAIL rand16 count: got %0d expected 300", got); end
  endtask

  task automatic test_reset_mid;
    int cyc = 0, lat;
    @(negedge clk);
    if16.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if16.in_valid = 1'b1;
      if16.a = 16'(16'h1111 * (i + 1)); if16.b = 16'h0101; if16.cin = 1'b0; if16.sub = 1'b0;
      @(negedge clk);
    end
    if16.in_valid = 1'b0;
    while (!if16.out_valid && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (if16.out_valid !== 1'b1 || if16.s !== 16'h1212)
      begin errors++; $display("FAIL rstmid pre: got v=%b s=%h expected 1/1212", if16.out_valid, if16.s); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if16.out_valid, if16.s, if16.in_ready} !== {1'b0, 16'h0, 1'b1})
      begin errors++; $display("FAIL rstmid async: got v=%b s=%h rdy=%b expected 0/0000/1",
        if16.out_valid, if16.s, if16.in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    if16.out_ready = 1'b1;
    @(negedge clk);
    if16.in_valid = 1'b1;
    if16.a = 16'h1234; if16.b = 16'h1111; if16.cin = 1'b0; if16.sub = 1'b0;
    @(negedge clk);
    if16.in_valid = 1'b0;
    lat = 1;
    while (!if16.out_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 4 || if16.s !== 16'h2345)
      begin errors++; $display("FAIL rstmid post: got lat=%0d s=%h expected 4/2345", lat, if16.s); end
  endtask

  task automatic test_w4_random;
    res_t q[$];
    int   acc[$];
    res_t e;
    int   sent = 0, got = 0, cyc = 0;
    bit   seen = 1'b0;
    while (got < 1000 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if4.out_ready = ($urandom_range(0, 3) != 0);
      if4.in_valid  = (sent < 1000) && ($urandom_range(0, 4) != 0);
      if4.a = 4'($urandom); if4.b = 4'($urandom);
      if4.cin = 1'($urandom); if4.sub = 1'($urandom);
      #1;
      if (if4.out_valid && !seen) begin
        checks++;
        if (acc.size() == 0 || cyc - acc[0] != 1)
          begin errors++; $display("FAIL w4 latency cyc %0d: got %0d expected 1", cyc,
            acc.size() == 0 ? -1 : cyc - acc[0]); end
        seen = 1'b1;
      end
      if (if4.in_valid && if4.in_ready) begin
        q.push_back(model(4, {12'h0, if4.a}, {12'h0, if4.b}, if4.cin, if4.sub));
        acc.push_back(cyc);
        sent++;
      end
      if (if4.out_valid && if4.out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL w4 spurious: got s=%h expected no result", if4.s); end
        else begin
          e = q.pop_front();
          void'(acc.pop_front());
          if ({12'h0, if4.s, if4.cout, if4.ovf} !== {e.s, e.cout, e.ovf})
            begin errors++; $display("FAIL w4 result %0d: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
              got, if4.s, if4.cout, if4.ovf, e.s[3:0], e.cout, e.ovf); end
        end
        seen = 1'b0;
        got++;
      end
    end
    if4.in_valid = 1'b0;
    checks++;
    if (got != 1000) begin errors++; $display("FAIL w4 count: got %0d expected 1000", got); end
  endtask

  initial begin
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0; if16.out_ready = 1'b1;
    if4.in_valid  = 1'b0; if4.a  = '0; if4.b  = '0; if4.cin  = 1'b0; if4.sub  = 1'b0; if4.out_ready  = 1'b1;
    test_reset;
    test_directed;
    test_back_to_back;
    test_random16;
    test_reset_mid;
    test_w4_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the arithmetic datapath. Operands are split into 4-bit lookahead groups. Each pipeline stage resolves one group with full lookahead carries and registers the group carry into the next stage. A valid/ready handshake with stall-on-backpressure carries one result per cycle at full throughput, and the block adds subtract mode and signed-overflow detection.

## Interface

- WIDTH, 16, operand/result width; multiple of 4, minimum 4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (borrow-in when sub=1)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry-out; in sub mode this is NOT borrow (1 = no borrow)
- ovf  output  1  two's-complement signed overflow

## Operation

- NG = WIDTH/4 groups; group k covers bits [4k+3:4k].
- Subtract: b_eff = ~b, c_in_eff = ~cin; add: b_eff = b, c_in_eff = cin.
- Per group: G = a&b_eff, P = a^b_eff; internal carries use two-level lookahead (no ripple within the group); sum = P ^ carry.
- Stage k computes group k using the registered carry from stage k-1 (stage 0 uses c_in_eff).
- Input skew: group k operands are delayed k stages. Output deskew: group k result is delayed NG-1-k stages, so all bits of s emerge together.
- cout = carry out of bit WIDTH-1. ovf = carry into bit WIDTH-1 XOR cout.
- Handshake: advance = ~out_valid | out_ready. in_ready = advance. The whole pipe (data and per-stage valid bits) shifts only on advance.
- A beat is accepted when in_valid & in_ready. Bubbles propagate as valid=0 stages.
- Output is held stable while out_valid & ~out_ready.
- Transactions are never dropped, duplicated or reordered.

## Timing

- Latency: NG cycles from acceptance to out_valid with no stall (WIDTH=16: 4 cycles; WIDTH=4: 1 cycle).
- Throughput: one result per cycle while out_ready=1.
- Reset (rst_n low, asynchronous): all stage valid bits 0, out_valid=0, s=0, cout=0, ovf=0, all carry registers 0. in_ready=1 in the first cycle after release.
- Reset mid-operation: all in-flight beats are discarded. out_valid falls immediately, without waiting for a clock edge.
- Simultaneous output pop and input accept in one cycle is legal and required for full throughput.
- in_ready is combinational from out_ready and out_valid only; there is no path from in_valid.

## Configuration

- CLA_SAT_EN defined: when ovf=1, s is clamped at the output register. If the sign of a is 0, s = 0111..1; if it is 1, s = 1000..0. ovf and cout are still reported unchanged.
- CLA_SAT_EN undefined: s is the wrapped modular result; the saturation logic is absent.

## Structure

- Package cla_pkg:
  - GROUP_W = 4
  - function num_groups(width)
  - typedef for the per-stage record {valid, carry, partial sum}
- Sub-module cla_group4:
  - Purely combinational 4-bit lookahead group.
  - Inputs: a4, b4, ci. Outputs: s4, co, c3 (carry into bit 3, needed for ovf on the top group).
  - cla_pipe_adder instantiates NG of them through a generate loop, with skew/deskew registers around them.

## Test plan

- WIDTH=16, add, a=0xFFFF, b=0x0001, cin=0 -> after 4 cycles s=0x0000, cout=1, ovf=0.
- WIDTH=16, add, a=0x7FFF, b=0x0001 -> s=0x8000, ovf=1 (with CLA_SAT_EN: s=0x7FFF, ovf=1).
- WIDTH=16, sub, a=0x0005, b=0x0007, cin=0 -> s=0xFFFE, cout=0, ovf=0. Same with a=0x8000, b=0x0001 -> s=0x7FFF, ovf=1 (sat: 0x8000).
- Stream 8 back-to-back beats (a=i, b=0x1000*i), drop out_ready for 3 cycles after the 2nd result:
  - in_ready is low exactly during the stall.
  - All 8 results arrive in order, correct.
  - Output is held stable during the stall.
- Assert rst_n low with 3 beats in flight -> out_valid=0 and s=0 immediately. After release, a new beat 0x1234+0x1111 gives s=0x2345 after 4 cycles with no stale output.
- WIDTH=4 instance, random 1000 beats with random out_ready against a reference model:
  - Latency is 1.
  - All s, cout and ovf values match.
